// File: rtl/vga_pixel_scheduler.sv
// rtl/vga_pixel_scheduler.sv - round-robin pixel write-port scheduler with optional frame clear
// The full-frame clear engine is compiled in only when VGA_SCHED_CLEAR_EN is defined.
module vga_pixel_scheduler #(
  parameter int COLOR_DEPTH = 9,
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int COLS        = 640,
  parameter int ROWS        = 480
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [nX-1:0]          x0,
  input  logic [nX-1:0]          x1,
  input  logic [nY-1:0]          y0,
  input  logic [nY-1:0]          y1,
  input  logic [COLOR_DEPTH-1:0] color0,
  input  logic [COLOR_DEPTH-1:0] color1,
  output logic                   ack0,
  output logic                   ack1,
  input  logic                   clear_start,
  input  logic [COLOR_DEPTH-1:0] clear_color,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic [nX-1:0]          x,
  output logic [nY-1:0]          y,
  output logic [COLOR_DEPTH-1:0] color,
  output logic                   write
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // One extra bit so COLS == 2**nX still compares correctly.
  localparam logic [nX:0]   COLS_L = (nX+1)'(COLS);
  localparam logic [nY:0]   ROWS_L = (nY+1)'(ROWS);
  localparam logic [nX-1:0] X_LAST = nX'(COLS-1);
  localparam logic [nY-1:0] Y_LAST = nY'(ROWS-1);

  state_t                   state, state_d;
  logic                     last_grant, last_grant_d;
  logic                     ack0_d, ack1_d, write_d, busy_d, done_d;
  logic [nX-1:0]            x_d;
  logic [nY-1:0]            y_d;
  logic [COLOR_DEPTH-1:0]   color_d;
  logic                     elig0, elig1, in_range0, in_range1;

  // A requester still seeing its ack is masked so a held req is not written twice.
  assign elig0     = req0 && !ack0;
  assign elig1     = req1 && !ack1;
  assign in_range0 = ({1'b0, x0} < COLS_L) && ({1'b0, y0} < ROWS_L);
  assign in_range1 = ({1'b0, x1} < COLS_L) && ({1'b0, y1} < ROWS_L);

`ifndef VGA_SCHED_CLEAR_EN
  logic unused_clear;
  assign unused_clear = ^{clear_start, clear_color};
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    write_d      = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    x_d          = x;
    y_d          = y;
    color_d      = color;
    case (state)
      IDLE: begin
`ifdef VGA_SCHED_CLEAR_EN
        if (clear_start) begin
          state_d = CLEAR;
          write_d = 1'b1;
          busy_d  = 1'b1;
          x_d     = '0;
          y_d     = '0;
          color_d = clear_color;
        end else
`endif
        if (elig0 && (!elig1 || last_grant)) begin
          ack0_d       = 1'b1;
          last_grant_d = 1'b0;
          x_d          = x0;
          y_d          = y0;
          color_d      = color0;
          write_d      = in_range0;
        end else if (elig1) begin
          ack1_d       = 1'b1;
          last_grant_d = 1'b1;
          x_d          = x1;
          y_d          = y1;
          color_d      = color1;
          write_d      = in_range1;
        end
      end
`ifdef VGA_SCHED_CLEAR_EN
      // The x/y output registers double as the sweep position; color holds the fill.
      CLEAR: begin
        if (x == X_LAST && y == Y_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          write_d = 1'b1;
          busy_d  = 1'b1;
          if (x == X_LAST) begin
            x_d = '0;
            y_d = y + nY'(1);
          end else begin
            x_d = x + nX'(1);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      write      <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      x          <= '0;
      y          <= '0;
      color      <= '0;
    end else begin
      last_grant <= last_grant_d;
      ack0       <= ack0_d;
      ack1       <= ack1_d;
      write      <= write_d;
      clear_busy <= busy_d;
      clear_done <= done_d;
      x          <= x_d;
      y          <= y_d;
      color      <= color_d;
    end
  end

endmodule

// File: tb/tb_vga_pixel_scheduler.sv
// tb/tb_vga_pixel_scheduler.sv - self-checking bench for vga_pixel_scheduler
// Clear-engine checks follow VGA_SCHED_CLEAR_EN; without it the bench checks that clear is ignored.
module tb_vga_pixel_scheduler;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  // full-size instance
  logic       req0, req1, clear_start;
  logic [9:0] x0, x1, x;
  logic [8:0] y0, y1, color0, color1, clear_color, y, color;
  logic       ack0, ack1, clear_busy, clear_done, write;

  // small-frame instance for the sweep
  logic       s_req0, s_req1, s_clear_start;
  logic [2:0] s_x0, s_x1, s_x;
  logic [1:0] s_y0, s_y1, s_y;
  logic [8:0] s_color0, s_color1, s_clear_color, s_color;
  logic       s_ack0, s_ack1, s_clear_busy, s_clear_done, s_write;

  vga_pixel_scheduler dut (
    .clock(clock), .resetn(resetn), .req0(req0), .req1(req1),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color0(color0), .color1(color1),
    .ack0(ack0), .ack1(ack1), .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .x(x), .y(y), .color(color), .write(write)
  );

  vga_pixel_scheduler #(.COLOR_DEPTH(9), .nX(3), .nY(2), .COLS(8), .ROWS(4)) dut_s (
    .clock(clock), .resetn(resetn), .req0(s_req0), .req1(s_req1),
    .x0(s_x0), .x1(s_x1), .y0(s_y0), .y1(s_y1), .color0(s_color0), .color1(s_color1),
    .ack0(s_ack0), .ack1(s_ack1), .clear_start(s_clear_start), .clear_color(s_clear_color),
    .clear_busy(s_clear_busy), .clear_done(s_clear_done),
    .x(s_x), .y(s_y), .color(s_color), .write(s_write)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic       r0;
    logic [9:0] px0;
    logic [8:0] py0;
    logic [8:0] pc0;
    logic       r1;
    logic [9:0] px1;
    logic [8:0] py1;
    logic [8:0] pc1;
    logic       ea0;
    logic       ea1;
    logic       ew;
    logic [9:0] ex;
    logic [8:0] ey;
    logic [8:0] ec;
  } vec_t;

  typedef struct {
    logic [9:0] px;
    logic [8:0] py;
    logic [8:0] pc;
  } pix_t;

  vec_t vecs[16];
  pix_t q0[$], q1[$];
  pix_t p, ep;
  logic a0, a1, hold0, hold1, m_ack0, m_ack1, m_last, e0, e1, n_ack0, n_ack1, ew;
  int   nwr, nbusy, ndone;

  task automatic idle_inputs();
    req0 = 0; req1 = 0; x0 = 0; x1 = 0; y0 = 0; y1 = 0; color0 = 0; color1 = 0;
    clear_start = 0; clear_color = 0;
    s_req0 = 0; s_req1 = 0; s_x0 = 0; s_x1 = 0; s_y0 = 0; s_y1 = 0;
    s_color0 = 0; s_color1 = 0; s_clear_start = 0; s_clear_color = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1 resetn = 1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //        r0 x0   y0   c0       r1 x1   y1   c1      a0 a1 w  ex   ey   ec
    vecs[0]  = '{1, 5,   7,   'h1FF, 0, 0,   0,   0,      1, 0, 1, 5,   7,   'h1FF};
    vecs[1]  = '{1, 5,   7,   'h1FF, 0, 0,   0,   0,      0, 0, 0, 0,   0,   0};
    vecs[2]  = '{1, 5,   7,   'h1FF, 0, 0,   0,   0,      1, 0, 1, 5,   7,   'h1FF};
    vecs[3]  = '{0, 0,   0,   0,     1, 640, 0,   'h003,  0, 1, 0, 640, 0,   'h003};
    vecs[4]  = '{1, 1,   2,   'h0AA, 1, 3,   4,   'h055,  1, 0, 1, 1,   2,   'h0AA};
    vecs[5]  = '{1, 1,   2,   'h0AA, 1, 3,   4,   'h055,  0, 1, 1, 3,   4,   'h055};
    vecs[6]  = '{1, 1,   2,   'h0AA, 1, 3,   4,   'h055,  1, 0, 1, 1,   2,   'h0AA};
    vecs[7]  = '{1, 1,   2,   'h0AA, 1, 3,   4,   'h055,  0, 1, 1, 3,   4,   'h055};
    vecs[8]  = '{1, 1,   2,   'h0AA, 1, 3,   4,   'h055,  1, 0, 1, 1,   2,   'h0AA};
    vecs[9]  = '{1, 1,   2,   'h0AA, 1, 3,   4,   'h055,  0, 1, 1, 3,   4,   'h055};
    vecs[10] = '{0, 0,   0,   0,     0, 0,   0,   0,      0, 0, 0, 0,   0,   0};
    vecs[11] = '{1, 10,  20,  'h100, 1, 30,  40,  'h0F0,  1, 0, 1, 10,  20,  'h100};
    vecs[12] = '{0, 0,   0,   0,     1, 0,   480, 'h011,  0, 1, 0, 0,   480, 'h011};
    vecs[13] = '{1, 639, 479, 'h001, 0, 0,   0,   0,      1, 0, 1, 639, 479, 'h001};
    vecs[14] = '{1, 639, 479, 'h001, 1, 639, 0,   'h002,  0, 1, 1, 639, 0,   'h002};
    vecs[15] = '{1, 639, 479, 'h001, 1, 639, 0,   'h002,  1, 0, 1, 639, 479, 'h001};

    idle_inputs();
    @(posedge clock);
    #1;
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_write", write, 0);
    check("rst_xyc", {x, y, color}, 0);
    check("rst_busy_done", {clear_busy, clear_done, s_clear_busy, s_clear_done}, 0);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      req0 = vecs[i].r0; x0 = vecs[i].px0; y0 = vecs[i].py0; color0 = vecs[i].pc0;
      req1 = vecs[i].r1; x1 = vecs[i].px1; y1 = vecs[i].py1; color1 = vecs[i].pc1;
      step();
      check($sformatf("vec%0d_ack0", i), ack0, vecs[i].ea0);
      check($sformatf("vec%0d_ack1", i), ack1, vecs[i].ea1);
      check($sformatf("vec%0d_write", i), write, vecs[i].ew);
      if (vecs[i].ea0 || vecs[i].ea1) begin
        check($sformatf("vec%0d_x", i), x, vecs[i].ex);
        check($sformatf("vec%0d_y", i), y, vecs[i].ey);
        check($sformatf("vec%0d_color", i), color, vecs[i].ec);
      end
    end

    // Asynchronous reset mid-traffic, right after requester 0 won.
    req0 = 0; req1 = 0;
    step();
    req0 = 1; x0 = 9; y0 = 9; color0 = 9'h033;
    step();
    check("pre_rst_ack0", ack0, 1);
    #2 resetn = 0;
    #1;
    check("async_rst_ack0", ack0, 0);
    check("async_rst_write", write, 0);
    check("async_rst_xyc", {x, y, color}, 0);
    req0 = 0;
    repeat (2) @(posedge clock);
    #1 resetn = 1;
    req0 = 1; x0 = 2; y0 = 3; color0 = 9'h044;
    req1 = 1; x1 = 4; y1 = 5; color1 = 9'h088;
    step();
    check("post_rst_ack0", ack0, 1);
    check("post_rst_ack1", ack1, 0);
    check("post_rst_x", x, 2);

    // Randomized requesters against a queue-based reference model.
    do_reset();
    m_ack0 = 0; m_ack1 = 0; m_last = 1; a0 = 0; a1 = 0; hold0 = 0; hold1 = 0;
    for (int i = 0; i < 60; i++) begin
      p.px = 10'($urandom_range(0, 700)); p.py = 9'($urandom_range(0, 511)); p.pc = 9'($urandom);
      q0.push_back(p);
      p.px = 10'($urandom_range(0, 700)); p.py = 9'($urandom_range(0, 511)); p.pc = 9'($urandom);
      q1.push_back(p);
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (hold0) begin q0.delete(0); a0 = 0; end
      if (hold1) begin q1.delete(0); a1 = 0; end
      hold0 = m_ack0;
      hold1 = m_ack1;
      if (!a0 && q0.size() > 0 && $urandom_range(0, 3) != 0) a0 = 1;
      if (!a1 && q1.size() > 0 && $urandom_range(0, 3) != 0) a1 = 1;
      req0 = a0;
      req1 = a1;
      if (a0) begin x0 = q0[0].px; y0 = q0[0].py; color0 = q0[0].pc; end
      if (a1) begin x1 = q1[0].px; y1 = q1[0].py; color1 = q1[0].pc; end
`ifndef VGA_SCHED_CLEAR_EN
      clear_start = ($urandom_range(0, 7) == 0);
      clear_color = 9'($urandom);
`endif
      e0 = a0 && !m_ack0;
      e1 = a1 && !m_ack1;
      n_ack0 = 0;
      n_ack1 = 0;
      if (e0 && e1) begin
        if (m_last) n_ack0 = 1; else n_ack1 = 1;
      end else if (e0) n_ack0 = 1;
      else if (e1) n_ack1 = 1;
      ep = '{px: 0, py: 0, pc: 0};
      if (n_ack0) begin ep = q0[0]; m_last = 0; end
      if (n_ack1) begin ep = q1[0]; m_last = 1; end
      ew = (n_ack0 || n_ack1) && (ep.px < 640) && (ep.py < 480);
      step();
      check("rnd_ack0", ack0, n_ack0);
      check("rnd_ack1", ack1, n_ack1);
      check("rnd_write", write, ew);
      if (n_ack0 || n_ack1) check("rnd_pixel", {x, y, color}, {ep.px, ep.py, ep.pc});
`ifndef VGA_SCHED_CLEAR_EN
      check("rnd_clear_idle", {clear_busy, clear_done}, 0);
`endif
      m_ack0 = n_ack0;
      m_ack1 = n_ack1;
    end
    if (hold0 || m_ack0) q0.delete(0);
    if (hold1 || m_ack1) q1.delete(0);
    check("rnd_drain0", q0.size(), 0);
    check("rnd_drain1", q1.size(), 0);

`ifdef VGA_SCHED_CLEAR_EN
    // Full sweep of an 8x4 frame with requester 0 held throughout.
    do_reset();
    s_req0 = 1; s_x0 = 1; s_y0 = 1; s_color0 = 9'h011;
    s_clear_start = 1; s_clear_color = 9'h0A5;
    step();
    s_clear_start = 0;
    nbusy = 0;
    ndone = 0;
    for (int k = 1; k <= 36; k++) begin
      nbusy += int'(s_clear_busy);
      ndone += int'(s_clear_done);
      if (k <= 32) begin
        check($sformatf("clr%0d_write", k), s_write, 1);
        check($sformatf("clr%0d_xy", k), {s_x, s_y}, {3'((k-1) % 8), 2'((k-1) / 8)});
        check($sformatf("clr%0d_color", k), s_color, 9'h0A5);
        check($sformatf("clr%0d_ack0", k), s_ack0, 0);
      end else if (k == 33) begin
        check("clr_done_pulse", s_clear_done, 1);
        check("clr_done_write", s_write, 0);
        check("clr_done_busy", s_clear_busy, 0);
        check("clr_done_ack0", s_ack0, 0);
      end else if (k == 34) begin
        check("clr_after_ack0", s_ack0, 1);
        check("clr_after_pixel", {s_write, s_x, s_y, s_color}, {1'b1, 3'd1, 2'd1, 9'h011});
        s_req0 = 0;
      end
      s_clear_start = (k == 10);
      s_clear_color = (k == 10) ? 9'h111 : 9'h0A5;
      step();
    end
    check("clr_busy_cycles", nbusy, 32);
    check("clr_done_count", ndone, 1);

    // Reset lands on the tenth fill write.
    do_reset();
    s_clear_start = 1; s_clear_color = 9'h0F0;
    step();
    s_clear_start = 0;
    repeat (9) step();
    check("mid_clr_pre", {s_write, s_x, s_y}, {1'b1, 3'd1, 2'd1});
    #2 resetn = 0;
    #1;
    check("mid_clr_write", s_write, 0);
    check("mid_clr_busy", s_clear_busy, 0);
    repeat (2) @(posedge clock);
    #1 resetn = 1;
    nwr = 0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      nwr += int'(s_write);
      ndone += int'(s_clear_done);
    end
    check("mid_clr_no_done", ndone, 0);
    check("mid_clr_no_write", nwr, 0);
`else
    do_reset();
    clear_start = 1; clear_color = 9'h0A5;
    s_clear_start = 1; s_clear_color = 9'h0A5;
    step();
    clear_start = 0;
    s_clear_start = 0;
    nwr = 0;
    nbusy = 0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      nwr += int'(write) + int'(s_write);
      nbusy += int'(clear_busy) + int'(s_clear_busy);
      ndone += int'(clear_done) + int'(s_clear_done);
      step();
    end
    check("noclr_writes", nwr, 0);
    check("noclr_busy", nbusy, 0);
    check("noclr_done", ndone, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
